// File: rtl/scaler_v_ctrl_pkg.sv
// Shared types and constants for the vertical scaler
// configuration controller.
package scaler_pkg;

  localparam int FRAC_BITS = 12;
  localparam int LINE_STEP = 1 << FRAC_BITS;
  localparam int MAX_LINE_SIZE = 1024;
  localparam logic [15:0] STEP_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    CHECK,
    PENDING
  } state_t;

endpackage

// File: rtl/scaler_v_ctrl_if.sv
// Resolution request channel: valid/ready plus the three
// geometry fields.
interface scaler_v_ctrl_if;

  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_in_h;
  logic [15:0] cfg_in_w;
  logic [15:0] cfg_out_h;

  modport master (
    output cfg_valid,
    output cfg_in_h,
    output cfg_in_w,
    output cfg_out_h,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_in_h,
    input  cfg_in_w,
    input  cfg_out_h,
    output cfg_ready
  );

endinterface

// File: rtl/scaler_v_ctrl_udiv_serial.sv
// Restoring unsigned divider, one quotient bit per clock.
// done flags the cycle whose closing edge writes the last bit.
module udiv_serial #(
  parameter int N_WIDTH = 28,
  parameter int D_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic [N_WIDTH-1:0] quotient,
  output logic               done
);

  localparam int CW = $clog2(N_WIDTH + 1);

  logic [D_WIDTH-1:0] rem;
  logic [D_WIDTH-1:0] dsr;
  logic [CW-1:0]      cnt;
  logic [D_WIDTH:0]   trial;
  logic               fit;

  assign trial = {rem, quotient[N_WIDTH-1]} - {1'b0, dsr};
  assign fit   = ~trial[D_WIDTH];
  assign done  = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      quotient <= '0;
    end else if (start) begin
      rem      <= '0;
      dsr      <= divisor;
      cnt      <= CW'(N_WIDTH);
      quotient <= dividend;
    end else if (cnt != '0) begin
      // quotient doubles as the dividend shift register
      rem <= fit ? trial[D_WIDTH-1:0]
                 : {rem[D_WIDTH-2:0], quotient[N_WIDTH-1]};
      quotient <= {quotient[N_WIDTH-2:0], fit};
      cnt      <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/scaler_v_ctrl.sv
// Vertical scaler config controller: divide, validate, and
// commit step/line size only on a frame start.
module scaler_v_ctrl #(
  parameter int LINE_STEP         = 4096,
  parameter int MAX_LINE_SIZE     = 1024,
  parameter int DEFAULT_STEP      = 4096,
  parameter int DEFAULT_LINE_SIZE = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  scaler_v_ctrl_if.slave   cfg,
  input  logic             de_i,
  input  logic             vs_i,
  output logic [15:0]      v_scale_step,
  output logic [15:0]      v_scale_line_size,
  output logic             cfg_applied,
  output logic             cfg_err,
  output logic             busy
);

  import scaler_pkg::*;

  localparam int FB = $clog2(LINE_STEP);
  localparam int NW = 16 + FB;
  localparam logic [16:0] MAX_W = 17'(MAX_LINE_SIZE);

  state_t state;
  state_t state_n;

  logic [15:0]   in_h;
  logic [15:0]   in_w;
  logic [15:0]   out_h;
  logic [15:0]   step_sh;
  logic [15:0]   size_sh;
  logic [NW-1:0] quo;
  logic          div_done;
  logic          accept;
  logic          fs;
  logic          reject;
  logic          commit;
  logic          err_c;
  logic [15:0]   step_c;

  assign fs            = de_i & vs_i;
  assign cfg.cfg_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;

  udiv_serial #(
    .N_WIDTH(NW),
    .D_WIDTH(16)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept),
    .dividend({cfg.cfg_in_h, {FB{1'b0}}}),
    .divisor (cfg.cfg_out_h),
    .quotient(quo),
    .done    (div_done)
  );

  assign reject = (out_h == '0)
               | (in_h == '0)
               | (in_w == '0)
               | ({1'b0, in_w} > MAX_W)
               | (quo == '0);

  assign step_c = (|quo[NW-1:16]) ? STEP_MAX : quo[15:0];

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    err_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_n = DIVIDE;
      end
      DIVIDE: begin
        if (div_done) state_n = CHECK;
      end
      CHECK: begin
        if (reject) begin
          err_c   = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = PENDING;
        end
      end
      PENDING: begin
        if (fs) begin
          commit  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      in_h              <= '0;
      in_w              <= '0;
      out_h             <= '0;
      step_sh           <= '0;
      size_sh           <= '0;
      v_scale_step      <= 16'(DEFAULT_STEP);
      v_scale_line_size <= 16'(DEFAULT_LINE_SIZE);
      cfg_applied       <= 1'b0;
      cfg_err           <= 1'b0;
    end else begin
      state       <= state_n;
      cfg_applied <= commit;
      cfg_err     <= err_c;
      if (accept) begin
        in_h  <= cfg.cfg_in_h;
        in_w  <= cfg.cfg_in_w;
        out_h <= cfg.cfg_out_h;
      end
      if (state == CHECK && !reject) begin
        step_sh <= step_c;
        size_sh <= in_w - 16'd1;
      end
      if (commit) begin
        v_scale_step      <= step_sh;
        v_scale_line_size <= size_sh;
      end
    end
  end

endmodule

// File: tb/tb_scaler_v_ctrl.sv
// Directed bench for scaler_v_ctrl: timing of accept,
// divide, reject and frame-synchronous commit.
module tb_scaler_v_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic de = 1'b0;
  logic vs = 1'b0;

  logic [15:0] a_step, a_size, b_step, b_size;
  logic a_app, a_err, a_busy;
  logic b_app, b_err, b_busy;

  int n_chk = 0;
  int n_fail = 0;

  scaler_v_ctrl_if ifa ();
  scaler_v_ctrl_if ifb ();

  always #5 clk = ~clk;

  scaler_v_ctrl #(
    .MAX_LINE_SIZE(2048)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg              (ifa),
    .de_i             (de),
    .vs_i             (vs),
    .v_scale_step     (a_step),
    .v_scale_line_size(a_size),
    .cfg_applied      (a_app),
    .cfg_err          (a_err),
    .busy             (a_busy)
  );

  scaler_v_ctrl u_dut_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg              (ifb),
    .de_i             (de),
    .vs_i             (vs),
    .v_scale_step     (b_step),
    .v_scale_line_size(b_size),
    .cfg_applied      (b_app),
    .cfg_err          (b_err),
    .busy             (b_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // accept happens on the edge this task returns #1 after
  task automatic send(input bit sel,
                      input logic [15:0] h,
                      input logic [15:0] w,
                      input logic [15:0] oh);
    @(negedge clk);
    if (sel) begin
      ifb.cfg_valid = 1'b1;
      ifb.cfg_in_h  = h;
      ifb.cfg_in_w  = w;
      ifb.cfg_out_h = oh;
    end else begin
      ifa.cfg_valid = 1'b1;
      ifa.cfg_in_h  = h;
      ifa.cfg_in_w  = w;
      ifa.cfg_out_h = oh;
    end
    @(posedge clk);
    #1;
    ifa.cfg_valid = 1'b0;
    ifb.cfg_valid = 1'b0;
  endtask

  task automatic fs_pulse();
    de = 1'b1;
    vs = 1'b1;
    @(posedge clk);
    #1;
    de = 1'b0;
    vs = 1'b0;
  endtask

  task automatic reject_t(input string tag, input bit sel,
                          input logic [15:0] h,
                          input logic [15:0] w,
                          input logic [15:0] oh,
                          input logic [15:0] es,
                          input logic [15:0] ez);
    send(sel, h, w, oh);
    repeat (28) @(posedge clk);
    #1;
    chk({tag, "_err_early"}, 32'(sel ? b_err : a_err), 0);
    @(posedge clk);
    #1;
    chk({tag, "_err"}, 32'(sel ? b_err : a_err), 1);
    chk({tag, "_ready"}, 32'(sel ? ifb.cfg_ready : ifa.cfg_ready), 1);
    chk({tag, "_step"}, 32'(sel ? b_step : a_step), 32'(es));
    chk({tag, "_size"}, 32'(sel ? b_size : a_size), 32'(ez));
    @(posedge clk);
    #1;
    chk({tag, "_err_clr"}, 32'(sel ? b_err : a_err), 0);
    chk({tag, "_busy"}, 32'(sel ? b_busy : a_busy), 0);
  endtask

  initial begin
    ifa.cfg_valid = 1'b0;
    ifa.cfg_in_h  = '0;
    ifa.cfg_in_w  = '0;
    ifa.cfg_out_h = '0;
    ifb.cfg_valid = 1'b0;
    ifb.cfg_in_h  = '0;
    ifb.cfg_in_w  = '0;
    ifb.cfg_out_h = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_step", 32'(a_step), 4096);
    chk("rst_size", 32'(a_size), 1023);
    chk("rst_ready", 32'(ifa.cfg_ready), 1);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_app", 32'(a_app), 0);
    chk("rst_err", 32'(a_err), 0);

    // nominal downscale, frame start arrives late
    send(1'b0, 16'd1080, 16'd1920, 16'd720);
    chk("nom_ready_lo", 32'(ifa.cfg_ready), 0);
    repeat (29) @(posedge clk);
    #1;
    chk("nom_pend_busy", 32'(a_busy), 1);
    chk("nom_pend_err", 32'(a_err), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("nom_hold_step", 32'(a_step), 4096);
    chk("nom_hold_app", 32'(a_app), 0);
    fs_pulse();
    chk("nom_step", 32'(a_step), 6144);
    chk("nom_size", 32'(a_size), 1919);
    chk("nom_app", 32'(a_app), 1);
    chk("nom_ready", 32'(ifa.cfg_ready), 1);
    @(posedge clk);
    #1;
    chk("nom_app_clr", 32'(a_app), 0);

    // frame start during DIVIDE is ignored
    send(1'b0, 16'd480, 16'd640, 16'd1080);
    repeat (9) @(posedge clk);
    #1;
    fs_pulse();
    chk("div_fs_app", 32'(a_app), 0);
    chk("div_fs_step", 32'(a_step), 6144);
    chk("div_fs_busy", 32'(a_busy), 1);
    repeat (89) @(posedge clk);
    #1;
    chk("div_wait_step", 32'(a_step), 6144);
    fs_pulse();
    chk("div_step", 32'(a_step), 1820);
    chk("div_size", 32'(a_size), 639);
    chk("div_app", 32'(a_app), 1);

    reject_t("rej_oh0", 1'b0, 16'd1080, 16'd1920, 16'd0,
             16'd1820, 16'd639);
    reject_t("rej_h0", 1'b0, 16'd0, 16'd1920, 16'd720,
             16'd1820, 16'd639);
    reject_t("rej_w0", 1'b0, 16'd1080, 16'd0, 16'd720,
             16'd1820, 16'd639);
    reject_t("rej_w2049", 1'b0, 16'd1080, 16'd2049, 16'd720,
             16'd1820, 16'd639);
    reject_t("rej_q0", 1'b0, 16'd1, 16'd640, 16'd8192,
             16'd1820, 16'd639);

    // saturation; fs held over CHECK and first PENDING edge
    send(1'b0, 16'd4096, 16'd800, 16'd1);
    repeat (28) @(posedge clk);
    #1;
    de = 1'b1;
    vs = 1'b1;
    @(posedge clk);
    #1;
    chk("sat_chk_ign", 32'(a_app), 0);
    @(posedge clk);
    #1;
    de = 1'b0;
    vs = 1'b0;
    chk("sat_step", 32'(a_step), 32'hFFFF);
    chk("sat_size", 32'(a_size), 799);
    chk("sat_app", 32'(a_app), 1);

    // async reset while a 2048 step is pending
    send(1'b0, 16'd540, 16'd2048, 16'd1080);
    repeat (29) @(posedge clk);
    #1;
    chk("rp_pend_busy", 32'(a_busy), 1);
    chk("rp_pend_err", 32'(a_err), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rp_step", 32'(a_step), 4096);
    chk("rp_size", 32'(a_size), 1023);
    chk("rp_ready", 32'(ifa.cfg_ready), 1);
    chk("rp_busy", 32'(a_busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fs_pulse();
    chk("rp_fs_app", 32'(a_app), 0);
    chk("rp_fs_step", 32'(a_step), 4096);

    // default line-buffer limit on the second instance
    reject_t("b_w1025", 1'b1, 16'd1080, 16'd1025, 16'd720,
             16'd4096, 16'd1023);
    send(1'b1, 16'd100, 16'd1024, 16'd100);
    repeat (29) @(posedge clk);
    #1;
    chk("b_w1024_busy", 32'(b_busy), 1);
    chk("b_w1024_err", 32'(b_err), 0);
    fs_pulse();
    chk("b_w1024_step", 32'(b_step), 4096);
    chk("b_w1024_size", 32'(b_size), 1023);
    chk("b_w1024_app", 32'(b_app), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
